mpram_rv: RTL and testbench

- Parametrised multi-port RAM: NUM_RD independent read ports with full valid/ready handshakes on both the address and data channels, plus NUM_WR write ports.
- Each read port has a 2-entry return buffer, so read data is never lost or overwritten under RREADY backpressure.
- Serves as the buffet storage array where several consumers read while fill and update paths write.

---
 rtl/buffets_mem_pkg.sv | 29 ++
 rtl/rd_ret_buf.sv | 55 +++++
 rtl/mpram_rv.sv | 92 +++++++++
 tb/tb_mpram_rv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/buffets_mem_pkg.sv
// Shared types and helpers for the mpram_rv buffet storage array.
// The WR_BYPASS_EN build uses wr_winner() to forward same-cycle write data.
package buffets_mem_pkg;

  localparam int RBUF_DEPTH = 2;
  localparam int MAX_WR     = 4;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } wr_sel_t;

  // Highest-index matching write port wins
  function automatic wr_sel_t wr_winner(input logic [MAX_WR-1:0] wr_match);
    wr_sel_t sel;
    sel.hit = 1'b0;
    sel.idx = 2'd0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (wr_match[j]) begin
        sel.hit = 1'b1;
        sel.idx = 2'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rd_ret_buf.sv
// Two-entry return FIFO for one read port; the head entry drives rdata.
module rd_ret_buf
  import buffets_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output occ_t                  count
);

  logic [DATA_WIDTH-1:0] buf_r [RBUF_DEPTH];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  occ_t                  count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Guard against overflow/underflow of the two-entry store
  always_comb begin
    push_ok_s = push & (count_r != occ_t'(RBUF_DEPTH));
    pop_ok_s  = pop & (count_r != 2'd0);
  end

  // Storage, pointers and occupancy; entries are zeroed so RDATA reads 0 in reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < RBUF_DEPTH; k++) buf_r[k] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        buf_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata  = buf_r[rd_ptr_r];
  assign rvalid = (count_r != 2'd0);
  assign count  = count_r;

endmodule

// File: rtl/mpram_rv.sv
// Multi-port RAM with valid/ready read ports and always-accepted write ports.
// Define WR_BYPASS_EN for write-first forwarding; default build is read-first.
module mpram_rv
  import buffets_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ARADDR,
  input  logic [NUM_RD-1:0]            ARVALID,
  output logic [NUM_RD-1:0]            ARREADY,
  output logic [NUM_RD*DATA_WIDTH-1:0] RDATA,
  output logic [NUM_RD-1:0]            RVALID,
  input  logic [NUM_RD-1:0]            RREADY,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] WADDR,
  input  logic [NUM_WR*DATA_WIDTH-1:0] WDATA,
  input  logic [NUM_WR-1:0]            WVALID
);

  localparam int SIZE = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [SIZE];

  // Write ports in ascending order so the highest index lands last; contents survive reset
  always_ff @(posedge CLK) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (WVALID[j]) mem_r[WADDR[j*ADDR_WIDTH +: ADDR_WIDTH]] <= WDATA[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr_s;
    logic                  accept_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    occ_t                  occ_s;
    occ_t                  occ_next_s;
    logic                  cred_ok_r;
`ifdef WR_BYPASS_EN
    logic [MAX_WR-1:0]     wr_match_s;
    wr_sel_t               sel_s;
`endif

    // Handshakes, array read and next credit count
    always_comb begin
      raddr_s    = ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      accept_s   = ARVALID[i] & ARREADY[i];
      pop_s      = RVALID[i] & RREADY[i];
`ifdef WR_BYPASS_EN
      wr_match_s = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        wr_match_s[j] = WVALID[j] & (WADDR[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr_s);
      end
      sel_s = wr_winner(wr_match_s);
      if (sel_s.hit) begin
        rd_word_s = WDATA[int'(sel_s.idx)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rd_word_s = mem_r[raddr_s];
      end
`else
      rd_word_s  = mem_r[raddr_s];
`endif
      occ_next_s = occ_s + {1'b0, accept_s} - {1'b0, pop_s};
    end

    // Credit flag is registered so ARREADY never depends on ARVALID or RREADY
    always_ff @(posedge CLK) begin
      if (RESET) cred_ok_r <= 1'b1;
      else       cred_ok_r <= (occ_next_s < occ_t'(RBUF_DEPTH));
    end

    assign ARREADY[i] = cred_ok_r & ~RESET;

    rd_ret_buf #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ret_buf (
      .CLK      (CLK),
      .RESET    (RESET),
      .push     (accept_s),
      .push_data(rd_word_s),
      .pop      (pop_s),
      .rdata    (RDATA[i*DATA_WIDTH +: DATA_WIDTH]),
      .rvalid   (RVALID[i]),
      .count    (occ_s)
    );
  end

endmodule

// File: tb/tb_mpram_rv.sv
// Self-checking bench for mpram_rv: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_mpram_rv;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NR*AW-1:0]  ARADDR;
  logic [NR-1:0]     ARVALID;
  logic [NR-1:0]     ARREADY;
  logic [NR*DW-1:0]  RDATA;
  logic [NR-1:0]     RVALID;
  logic [NR-1:0]     RREADY;
  logic [NW*AW-1:0]  WADDR;
  logic [NW*DW-1:0]  WDATA;
  logic [NW-1:0]     WVALID;

  int nchk  = 0;
  int npass = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mem_m [1024];
  logic [DW-1:0] mq [NR][$];

  mpram_rv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .CLK(CLK), .RESET(RESET), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .WADDR(WADDR), .WDATA(WDATA), .WVALID(WVALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int port, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s port%0d: got %h expected %h at %0t", nm, port, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: per-port FIFO of expected words, updated on each clock edge
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        bit acc, pop;
        a   = ARADDR[i*AW +: AW];
        acc = ARVALID[i] && (mq[i].size() < 2);
        pop = RREADY[i] && (mq[i].size() > 0);
        v   = mem_m[a];
`ifdef WR_BYPASS_EN
        for (int j = 0; j < NW; j++)
          if (WVALID[j] && WADDR[j*AW +: AW] == a) v = WDATA[j*DW +: DW];
`endif
        if (pop) void'(mq[i].pop_front());
        if (acc) mq[i].push_back(v);
      end
    end
    for (int j = 0; j < NW; j++)
      if (WVALID[j]) mem_m[WADDR[j*AW +: AW]] = WDATA[j*DW +: DW];
  end

  // Compare DUT outputs against the model away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) begin
        chk("rvalid", i, {63'd0, RVALID[i]}, {63'd0, mq[i].size() != 0});
        if (mq[i].size() != 0) chk("rdata", i, RDATA[i*DW +: DW], mq[i][0]);
        chk("arready", i, {63'd0, ARREADY[i]}, {63'd0, (!RESET && mq[i].size() < 2)});
      end
    end
  end

  initial begin
    logic [DW-1:0] exp_rw;
`ifdef WR_BYPASS_EN
    exp_rw = 64'h22;
`else
    exp_rw = 64'h11;
`endif
    for (int k = 0; k < 1024; k++) mem_m[k] = '0;
    RESET = 1'b1; ARADDR = '0; ARVALID = '0; RREADY = '0;
    WADDR = '0; WDATA = '0; WVALID = '0;

    // Reset and release
    step();
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_rdata", 0, RDATA[DW-1:0], 64'd0);
    chk("rst_arready", 0, {62'd0, ARREADY}, 64'd0);
    step(); step();
    RESET = 1'b0;
    @(negedge CLK);
    chk("rel_arready", 0, {62'd0, ARREADY}, 64'd3);

    // Fill addresses 0..15 with 0x100+k via port 0
    for (int k = 0; k < 16; k++) begin
      WVALID = 2'b01; WADDR[AW-1:0] = 10'(k); WDATA[DW-1:0] = 64'h100 + 64'(k);
      step();
    end
    WVALID = 2'b00;

    // Streaming on port 0
    RREADY = 2'b11; ARVALID = 2'b01; ARADDR[AW-1:0] = 10'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("stream_arready", 0, {63'd0, ARREADY[0]}, 64'd1);
      if (k > 0) chk("stream_rdata", 0, RDATA[DW-1:0], 64'h100 + 64'(k - 1));
      step();
      if (k < 7) ARADDR[AW-1:0] = 10'(k + 1);
      else ARVALID = 2'b00;
    end
    @(negedge CLK);
    chk("stream_last", 0, RDATA[DW-1:0], 64'h107);
    step();

    // Backpressure on port 1
    RREADY = 2'b01; ARVALID = 2'b10; ARADDR[2*AW-1:AW] = 10'd3;
    step(); ARADDR[2*AW-1:AW] = 10'd4;
    step(); ARADDR[2*AW-1:AW] = 10'd5;
    step();
    @(negedge CLK);
    chk("bp_arready", 1, {63'd0, ARREADY[1]}, 64'd0);
    chk("bp_hold", 1, RDATA[2*DW-1:DW], 64'h103);
    step();
    @(negedge CLK);
    chk("bp_stable", 1, RDATA[2*DW-1:DW], 64'h103);
    RREADY = 2'b11;
    step();
    @(negedge CLK);
    chk("bp_second", 1, RDATA[2*DW-1:DW], 64'h104);
    chk("bp_reopen", 1, {63'd0, ARREADY[1]}, 64'd1);
    step(); ARVALID = 2'b00;
    @(negedge CLK);
    chk("bp_third", 1, RDATA[2*DW-1:DW], 64'h105);
    step();

    // Write collision: highest port wins
    WVALID = 2'b11; WADDR = {10'd9, 10'd9}; WDATA = {64'hB, 64'hA};
    step();
    WVALID = 2'b00; ARVALID = 2'b01; ARADDR[AW-1:0] = 10'd9;
    step(); ARVALID = 2'b00;
    @(negedge CLK);
    chk("collision", 0, RDATA[DW-1:0], 64'hB);
    step();

    // Read and write of the same address in one cycle
    WVALID = 2'b01; WADDR[AW-1:0] = 10'd5; WDATA[DW-1:0] = 64'h11;
    step();
    WDATA[DW-1:0] = 64'h22; ARVALID = 2'b01; ARADDR[AW-1:0] = 10'd5;
    step(); WVALID = 2'b00; ARVALID = 2'b00;
    @(negedge CLK);
    chk("rw_same", 0, RDATA[DW-1:0], exp_rw);
    step();
    ARVALID = 2'b01;
    step(); ARVALID = 2'b00;
    @(negedge CLK);
    chk("rw_after", 0, RDATA[DW-1:0], 64'h22);
    step();

    // Reset with two entries buffered on port 0
    RREADY = 2'b00; ARVALID = 2'b01; ARADDR[AW-1:0] = 10'd1;
    step(); ARADDR[AW-1:0] = 10'd2;
    step(); ARVALID = 2'b00;
    @(negedge CLK);
    chk("mid_full", 0, {63'd0, RVALID[0]}, 64'd1);
    step(); RESET = 1'b1;
    step(); RESET = 1'b0;
    @(negedge CLK);
    chk("mid_rvalid", 0, {63'd0, RVALID[0]}, 64'd0);
    chk("mid_arready", 0, {63'd0, ARREADY[0]}, 64'd1);
    ARVALID = 2'b01; ARADDR[AW-1:0] = 10'd0; RREADY = 2'b11;
    step(); ARVALID = 2'b00;
    @(negedge CLK);
    chk("mid_retained", 0, RDATA[DW-1:0], 64'h100);
    step();

    // Randomized traffic over a small address window to force collisions
    for (int n = 0; n < 2000; n++) begin
      RESET   = ($urandom_range(99) == 0);
      ARVALID = 2'($urandom);
      RREADY  = 2'($urandom);
      WVALID  = 2'($urandom);
      for (int i = 0; i < NR; i++) ARADDR[i*AW +: AW] = 10'($urandom_range(15));
      for (int j = 0; j < NW; j++) begin
        WADDR[j*AW +: AW] = 10'($urandom_range(15));
        WDATA[j*DW +: DW] = {$urandom, $urandom};
      end
      step();
    end

    RESET = 1'b0; ARVALID = 2'b00; RREADY = 2'b11; WVALID = 2'b00;
    step(); step(); step();
    @(negedge CLK);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
